md_unit: RTL



---
 rtl/md_unit_pkg.sv | 18 +
 rtl/md_unit_div_iter.sv | 95 +++++++++
 rtl/md_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared types and constants for the multiply/divide unit and its iterative divider.
package md_unit_pkg;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdDiv  = 2'd1,
    MdFin  = 2'd2
  } md_state_e;

  localparam int unsigned MdDivSteps = 32;
  localparam int unsigned MdCntW     = $clog2(MdDivSteps);

  // Two's-complement magnitude; unsigned operands pass through unchanged.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_unit_div_iter.sv
// Iterative 32-step restoring divider with sign fix-up; done pulses in the FIN cycle.
module md_unit_div_iter
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  md_state_e         state_q, state_d;
  logic [MdCntW-1:0] cnt_q, cnt_d;
  logic [31:0]       dvd_q, dvd_d;  // dividend shifts out as quotient shifts in
  logic [31:0]       dvs_q, dvs_d;
  logic [31:0]       rem_q, rem_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [32:0]       rem_sh;
  logic [32:0]       trial;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rem_sh  = {rem_q, dvd_q[31]};
    trial   = rem_sh - {1'b0, dvs_q};
    unique case (state_q)
      MdIdle: begin
        if (start) begin
          state_d = MdDiv;
          cnt_d   = '0;
          dvd_d   = md_mag(dividend, is_signed);
          dvs_d   = md_mag(divisor, is_signed);
          rem_d   = '0;
          negq_d  = is_signed & (dividend[31] ^ divisor[31]);
          negr_d  = is_signed & dividend[31];
        end
      end
      MdDiv: begin
        if (abort) begin
          state_d = MdIdle;
        end else begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            dvd_d = {dvd_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            dvd_d = {dvd_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MdCntW'(MdDivSteps - 1)) state_d = MdFin;
        end
      end
      MdFin:   state_d = MdIdle;
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy = (state_q != MdIdle);
  assign done = (state_q == MdFin) & ~abort;
  assign quot = negq_q ? (~dvd_q + 32'd1) : dvd_q;
  assign rem  = negr_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/md_unit.sv
// HI/LO register file, single-cycle multiplier and issue/stall control around the divider.
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        flush,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hilo_read,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        issue;
  logic        any_strobe;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign issue      = op_valid & ~flush & ~div_busy;
  assign any_strobe = is_mult | is_multu | is_div | is_divu | hi_wen | lo_wen;

  // Low 64 bits of a 64x64 product of sign/zero-extended operands are exact.
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  md_unit_div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (issue & (is_div | is_divu)),
    .is_signed (is_div),
    .abort     (flush),
    .dividend  (rs_data),
    .divisor   (rt_data),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = div_rem;
      lo_d = div_quot;
    end else if (issue && !(is_div || is_divu)) begin
      if (is_mult) begin
        {hi_d, lo_d} = prod_s;
      end else if (is_multu) begin
        {hi_d, lo_d} = prod_u;
      end else begin
        if (hi_wen) hi_d = rs_data;
        if (lo_wen) lo_d = rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = div_busy;
  assign stall = div_busy & op_valid & (hilo_read | any_strobe);

endmodule
